// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: 640x480@60 VGA timing, 2x-doubled frame-buffer reads, pixel-aligned rgb/sync.
// Ports: clk, reset (async, active-high); fb_addr -> frame buffer, fb_data <- frame buffer;
//   rgb/hsync/vsync/video_on -> VGA pins; frame_start pulses when (h,v) wraps to (0,0);
//   test_pattern selects colour bars, present only with VGA_TEST_PATTERN_EN defined.
module vga_frame_scanner #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_WIDTH = 320
) (
  input  logic        clk,
  input  logic        reset,
  output logic [16:0] fb_addr,
  input  logic [11:0] fb_data,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic        test_pattern
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [16:0] fb_addr_q, fb_addr_d, line_base;
  logic hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d;
  logic [11:0] rgb_q, rgb_d, pix;
  logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic tick, h_end, v_end, hs_n, vs_n, act;
`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] h1_q, h1_d;
  logic [11:0] bar;
  // bar index = h1/80 as a compare chain, no divider
  always_comb begin
    h1_d = tick ? h_q : h1_q;
    bar  = h1_q < 10'd80  ? 12'hFFF :
           h1_q < 10'd160 ? 12'hFF0 :
           h1_q < 10'd240 ? 12'h0FF :
           h1_q < 10'd320 ? 12'h0F0 :
           h1_q < 10'd400 ? 12'hF0F :
           h1_q < 10'd480 ? 12'hF00 :
           h1_q < 10'd560 ? 12'h00F : 12'h000;
    pix  = test_pattern ? bar : fb_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) h1_q <= '0;
    else       h1_q <= h1_d;
`else
  assign pix = fb_data;
`endif
  always_comb begin
    tick  = div_q == DW'(CLK_DIV - 1);
    h_end = h_q == 10'(H_TOTAL - 1);
    v_end = v_q == 10'(V_TOTAL - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = tick ? (h_end ? '0 : h_q + 10'd1) : h_q;
    v_d   = (tick && h_end) ? (v_end ? '0 : v_q + 10'd1) : v_q;
    hs_n  = !(h_q >= 10'(H_ACTIVE + H_FP) && h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
    vs_n  = !(v_q >= 10'(V_ACTIVE + V_FP) && v_q < 10'(V_ACTIVE + V_FP + V_SYNC));
    act   = h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
    // (v>>1)*320 as (v>>1)<<8 + (v>>1)<<6; max 239*320+319 = 76799 fits 17 bits
    line_base = (FB_WIDTH == 320) ? (17'(v_q[9:1]) << 8) + (17'(v_q[9:1]) << 6)
                                  : 17'(v_q[9:1]) * 17'(FB_WIDTH);
    fb_addr_d  = (tick && act) ? line_base + 17'(h_q[9:1]) : fb_addr_q;
    hs1_d      = tick ? hs_n : hs1_q;
    vs1_d      = tick ? vs_n : vs1_q;
    act1_d     = tick ? act : act1_q;
    rgb_d      = tick ? (act1_q ? pix : 12'h000) : rgb_q;
    hsync_d    = tick ? hs1_q : hsync_q;
    vsync_d    = tick ? vs1_q : vsync_q;
    video_on_d = tick ? act1_q : video_on_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      fb_addr_q  <= '0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      act1_q     <= 1'b0;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      fb_addr_q  <= fb_addr_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      act1_q     <= act1_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  // frame_start is the wrap itself, not pipelined with the pixel path
  assign frame_start = tick && h_end && v_end;
  assign fb_addr     = fb_addr_q;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: checks vga_frame_scanner against an arithmetic timing model (short vertical geometry).
module tb_vga_frame_scanner;
  localparam int CD = 4;
  localparam int HA = 640;
  localparam int HT = 800;
  localparam int VA = 6;
  localparam int VFP = 1;
  localparam int VS = 2;
  localparam int VBP = 1;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int F = HT * VT;
  logic clk = 1'b0;
  logic reset;
  logic [16:0] fb_addr;
  logic [11:0] fb_data, rgb, seed;
  logic hsync, vsync, video_on, frame_start, tp;
  int tests = 0, fails = 0, ne = 0;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
  always #5 clk = ~clk;
  assign fb_data = fb_addr[11:0] ^ seed;
  vga_frame_scanner #(.CLK_DIV(CD), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)) dut (
    .clk(clk), .reset(reset), .fb_addr(fb_addr), .fb_data(fb_data), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
`ifdef VGA_TEST_PATTERN_EN
    , .test_pattern(tp)
`endif
  );
  function automatic int addr(int h, int v);
    return (v / 2) * 320 + h / 2;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h ne=%0d t=%0t", tag, got, exp, ne, $time);
    end
  endtask
  task automatic check_all();
    int t, q, h, v, q1, h1, v1, ea;
    logic [11:0] er;
    logic ehs, evs, eon;
    t = ne / CD;
    if (t < 2) begin
      er = 12'h000; ehs = 1'b1; evs = 1'b1; eon = 1'b0;
    end else begin
      q = (t - 2) % F;
      h = q % HT;
      v = q / HT;
      eon = h < HA && v < VA;
      ehs = !(h >= HA + 16 && h < HA + 16 + 96);
      evs = !(v >= VA + VFP && v < VA + VFP + VS);
      er = !eon ? 12'h000 : tp ? bars[h / 80] : 12'(addr(h, v)) ^ seed;
    end
    if (t == 0) ea = 0;
    else begin
      q1 = (t - 1) % F;
      h1 = q1 % HT;
      v1 = q1 / HT;
      ea = (v1 >= VA) ? addr(HA - 1, VA - 1) : addr((h1 < HA) ? h1 : HA - 1, v1);
    end
    chk("rgb", 32'(rgb), 32'(er));
    chk("hsync", 32'(hsync), 32'(ehs));
    chk("vsync", 32'(vsync), 32'(evs));
    chk("video_on", 32'(video_on), 32'(eon));
    chk("fb_addr", 32'(fb_addr), ea);
    chk("frame_start", 32'(frame_start), 32'(ne % CD == CD - 1 && t % F == F - 1));
  endtask
  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      if (!reset) ne++;
      @(negedge clk);
      check_all();
    end
  endtask
  task automatic async_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    ne = 0;
    #1 check_all();
    run(10);
    reset = 1'b0;
  endtask
  initial begin
    seed = 12'($urandom);
    tp = 1'b0;
    reset = 1'b1;
    run(10);
    reset = 1'b0;
    run(F * CD + 2000 + int'($urandom_range(0, 1000)));
    run(int'($urandom_range(1000, 3000)));
    async_reset();
    run(3000 + int'($urandom_range(0, 400)));
`ifdef VGA_TEST_PATTERN_EN
    @(negedge clk);
    #1 reset = 1'b1;
    tp = 1'b1;
    ne = 0;
    run(4);
    reset = 1'b0;
    run(3400);
    tp = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
